// File: rtl/stm32_req_scheduler.sv
// Round-robin scheduler for the four STM32 service interrupts: grants one request,
// waits for the synchronised STM32 ready edge (or a timeout) and pulses RELEASE to the CPU.
module stm32_req_scheduler #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic       CLKCPU_A,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       ACK_IN,
  output logic [3:0] INT_OUT,
  output logic [1:0] GRANT_ID,
  output logic       BUSY,
  output logic       RELEASE,
  output logic       TIMEOUT_ERR,
  output logic [7:0] ERR_CNT
);

  if (TIMEOUT < 4 || (2 ** CNT_W) <= TIMEOUT) begin : g_param_check
    $error("stm32_req_scheduler: TIMEOUT must be >= 4 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic             ack_p0;
  logic             ack_p1;
  logic             ack_p2;
  logic             ack_edge;
  logic [2:0]       pick;
  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic             abort;
  logic             expired;
  logic [3:0]       int_nxt;
  logic [1:0]       gid_nxt;
  logic             rel_nxt;
  logic             terr_nxt;
  logic [7:0]       err_nxt;

  // First set request at or above base, wrapping mod 4; bit 2 flags a hit.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0..p2: ACK_IN synchroniser (s1, s2, s3); the rising edge is seen between p1 and p2.
  always_ff @(posedge CLKCPU_A) begin
    if (RST) begin
      ack_p0 <= 1'b0;
      ack_p1 <= 1'b0;
      ack_p2 <= 1'b0;
    end else begin
      ack_p0 <= ACK_IN;
      ack_p1 <= ack_p0;
      ack_p2 <= ack_p1;
    end
  end

  assign ack_edge = ack_p1 & ~ack_p2;
  assign pick     = rr_pick(REQ, ptr);
  assign pick_vld = pick[2];
  assign pick_idx = pick[1:0];
  assign abort    = ~REQ[GRANT_ID];
  assign expired  = (cnt == CNT_LAST);

  always_ff @(posedge CLKCPU_A) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE: begin
        if (abort)                    state_nxt = IDLE;
        else if (ack_edge || expired) state_nxt = DONE;
      end
      DONE:    if (abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Abort outranks the ack edge, which outranks the timeout.
  always_comb begin
    cnt_nxt  = cnt;
    ptr_nxt  = ptr;
    int_nxt  = INT_OUT;
    gid_nxt  = GRANT_ID;
    rel_nxt  = 1'b0;
    terr_nxt = 1'b0;
    err_nxt  = ERR_CNT;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gid_nxt = pick_idx;
          int_nxt = 4'b0001 << pick_idx;
          cnt_nxt = '0;
        end
      end
      ISSUE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (abort) begin
          int_nxt = 4'b0000;
        end else if (ack_edge) begin
          int_nxt = 4'b0000;
          rel_nxt = 1'b1;
        end else if (expired) begin
          int_nxt  = 4'b0000;
          rel_nxt  = 1'b1;
          terr_nxt = 1'b1;
          err_nxt  = sat_inc(ERR_CNT);
        end
      end
      DONE: begin
        if (abort) ptr_nxt = GRANT_ID + 2'd1;
      end
      default: int_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge CLKCPU_A) begin
    if (RST) begin
      INT_OUT     <= 4'b0000;
      GRANT_ID    <= 2'd0;
      BUSY        <= 1'b0;
      RELEASE     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      ERR_CNT     <= 8'd0;
    end else begin
      INT_OUT     <= int_nxt;
      GRANT_ID    <= gid_nxt;
      BUSY        <= (state_nxt != IDLE);
      RELEASE     <= rel_nxt;
      TIMEOUT_ERR <= terr_nxt;
      ERR_CNT     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_stm32_req_scheduler.sv
// Bench for stm32_req_scheduler: directed scenarios plus a randomized run against a
// transaction-level reference model stepped once per clock edge.
module tb_stm32_req_scheduler;
  localparam int TO = 16;
  localparam int CW = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] int_out;
  logic [1:0] gid;
  logic       busy;
  logic       rel;
  logic       terr;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = waiting, 1 = interrupt raised, 2 = released, waiting for CPU.
  int         m_mode;
  int         m_ptr;
  int         m_gid;
  int         m_age;
  int         m_err;
  logic [3:0] m_int;
  logic       m_busy;
  logic       m_rel;
  logic       m_terr;
  bit   [2:0] m_hist;

  stm32_req_scheduler #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLKCPU_A   (clk),
    .RST        (rst),
    .REQ        (req),
    .ACK_IN     (ack),
    .INT_OUT    (int_out),
    .GRANT_ID   (gid),
    .BUSY       (busy),
    .RELEASE    (rel),
    .TIMEOUT_ERR(terr),
    .ERR_CNT    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit ack_seen;
    int idx;
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_gid = 0; m_age = 0; m_err = 0;
      m_int = 4'b0000; m_busy = 1'b0; m_rel = 1'b0; m_terr = 1'b0;
      m_hist = 3'b000;
    end else begin
      // ACK high two edges ago but low three edges ago counts as a fresh ready edge.
      ack_seen = m_hist[1] && !m_hist[2];
      m_rel = 1'b0;
      m_terr = 1'b0;
      if (m_mode == 0) begin
        for (int i = 0; i < 4; i++) begin
          idx = (m_ptr + i) % 4;
          if (m_mode == 0 && req[idx]) begin
            m_gid = idx; m_int = 4'(1 << idx); m_age = 0; m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (!req[m_gid]) begin
          m_int = 4'b0000; m_mode = 0;
        end else if (ack_seen) begin
          m_int = 4'b0000; m_rel = 1'b1; m_mode = 2;
        end else if (m_age == TO - 1) begin
          m_int = 4'b0000; m_rel = 1'b1; m_terr = 1'b1; m_mode = 2;
          if (m_err < 255) m_err = m_err + 1;
        end
        m_age = m_age + 1;
      end else begin
        if (!req[m_gid]) begin
          m_ptr = (m_gid + 1) % 4; m_mode = 0;
        end
      end
      m_busy = (m_mode != 0);
      m_hist = {m_hist[1:0], ack};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; ack = 1'b0;
    tick(); tick();
    checks++; if (int_out !== 4'b0000) begin errors++; $display("FAIL reset_int: got %b expected 0000", int_out); end
    checks++; if (gid !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d expected 0", gid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rel !== 1'b0) begin errors++; $display("FAIL reset_release: got %b expected 0", rel); end
    checks++; if (terr !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", terr); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    req = 4'b0001;
    tick();
    checks++; if (int_out !== 4'b0001) begin errors++; $display("FAIL single_int: got %b expected 0001", int_out); end
    checks++; if (gid !== 2'd0) begin errors++; $display("FAIL single_gid: got %0d expected 0", gid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    n = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      n += int'(rel);
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL single_early_release: got %0d pulses expected 0", n); end
    ack = 1'b1;
    tick(); tick();
    checks++; if (rel !== 1'b0) begin errors++; $display("FAIL single_rel_latency: got %b expected 0", rel); end
    tick();
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL single_release: got %b expected 1", rel); end
    checks++; if (terr !== 1'b0) begin errors++; $display("FAIL single_terr: got %b expected 0", terr); end
    checks++; if (int_out !== 4'b0000) begin errors++; $display("FAIL single_int_clear: got %b expected 0000", int_out); end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(rel);
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL single_extra_release: got %0d pulses expected 0", n); end
    req = 4'b0000; ack = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp = i % 4;
      checks++; if (gid !== 2'(exp)) begin errors++; $display("FAIL rr_order: got %0d expected %0d", gid, exp); end
      checks++; if (int_out !== 4'(1 << exp)) begin errors++; $display("FAIL rr_int: got %b expected %b", int_out, 4'(1 << exp)); end
      ack = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        checks++; if ($countones(int_out) > 1) begin errors++; $display("FAIL rr_onehot: got %b expected at most one bit", int_out); end
      end
      checks++; if (rel !== 1'b1) begin errors++; $display("FAIL rr_release: got %b expected 1", rel); end
      ack = 1'b0;
      req[exp] = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_gap: got busy %b expected 0", busy); end
      req[exp] = 1'b1;
      tick();
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    int exp;
    do_reset();
    req = 4'b0100;
    tick();
    checks++; if (int_out !== 4'b0100) begin errors++; $display("FAIL to_int: got %b expected 0100", int_out); end
    n = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      n += int'(rel);
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL to_early_release: got %0d pulses expected 0", n); end
    tick();
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL to_release: got %b expected 1", rel); end
    checks++; if (terr !== 1'b1) begin errors++; $display("FAIL to_terr: got %b expected 1", terr); end
    checks++; if (int_out !== 4'b0000) begin errors++; $display("FAIL to_int_clear: got %b expected 0000", int_out); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL to_errcnt_first: got %0d expected 1", err_cnt); end
    req = 4'b0000;
    tick();
    for (int i = 0; i < 255; i++) begin
      req = 4'b0100;
      for (int j = 0; j < TO + 1; j++) tick();
      req = 4'b0000;
      tick();
      exp = (i + 2 > 255) ? 255 : i + 2;
      checks++; if (err_cnt !== 8'(exp)) begin errors++; $display("FAIL to_errcnt_sat: got %0d expected %0d", err_cnt, exp); end
    end
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    req = 4'b0010;
    tick();
    checks++; if (gid !== 2'd1) begin errors++; $display("FAIL abort_gid: got %0d expected 1", gid); end
    for (int i = 0; i < 5; i++) tick();
    req = 4'b0000;
    tick();
    checks++; if (int_out !== 4'b0000) begin errors++; $display("FAIL abort_int: got %b expected 0000", int_out); end
    checks++; if (rel !== 1'b0) begin errors++; $display("FAIL abort_release: got %b expected 0", rel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    ack = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(rel);
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL stale_ack_idle: got %0d pulses expected 0", n); end
    req = 4'b1111;
    tick();
    checks++; if (gid !== 2'd0) begin errors++; $display("FAIL abort_ptr: got %0d expected 0", gid); end
    checks++; if (int_out !== 4'b0001) begin errors++; $display("FAIL abort_regrant: got %b expected 0001", int_out); end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n += int'(rel);
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL stale_ack_kept: got %0d pulses expected 0", n); end
    ack = 1'b0; req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < TO - 3; i++) tick();
    ack = 1'b1;
    tick(); tick();
    checks++; if (rel !== 1'b0) begin errors++; $display("FAIL coll_early: got %b expected 0", rel); end
    tick();
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL coll_release: got %b expected 1", rel); end
    checks++; if (terr !== 1'b0) begin errors++; $display("FAIL coll_terr: got %b expected 0", terr); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL coll_errcnt: got %0d expected 0", err_cnt); end
    ack = 1'b0; req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b1000;
    for (int i = 0; i < TO + 1; i++) tick();
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    checks++; if (int_out !== 4'b1000) begin errors++; $display("FAIL rstmid_grant: got %b expected 1000", int_out); end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (int_out !== 4'b0000) begin errors++; $display("FAIL rstmid_int: got %b expected 0000", int_out); end
    checks++; if (gid !== 2'd0) begin errors++; $display("FAIL rstmid_gid: got %0d expected 0", gid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (rel !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b expected 0", rel); end
    checks++; if (terr !== 1'b0) begin errors++; $display("FAIL rstmid_terr: got %b expected 0", terr); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_errcnt: got %0d expected 0", err_cnt); end
    rst = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    int idx;
    int div;
    logic [17:0] got;
    logic [17:0] want;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      div = ((c / 500) % 2 == 0) ? 4 : 40;
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        req[idx] = ~req[idx];
      end
      if ($urandom_range(0, div - 1) == 0) ack = ~ack;
      rst = ($urandom_range(0, 399) == 0);
      tick();
      got  = {int_out, gid, busy, rel, terr, err_cnt};
      want = {m_int, 2'(m_gid), m_busy, m_rel, m_terr, 8'(m_err)};
      checks++; if (got !== want) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", c, got, want); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_abort();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
